// File: rtl/uart_receive_deserializer.sv
// uart_receive_deserializer: oversampled UART receiver with a one-deep held byte and error flags
module uart_receive_deserializer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       RX_clock_enable,
   input  logic       UART_RX_I,
   input  logic       Unload_data,
   output logic [7:0] RX_data,
   output logic       Empty,
   output logic       Frame_error,
   output logic       Overrun
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q;
   logic            sync_q, rx_q, rx_prev_q;
   logic            empty_q, ferr_q, ovr_q;
   logic            done;

   // Two-flop synchronizer runs every clock; the edge-detect copy only moves on enable ticks
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sync_q    <= 1'b1;
         rx_q      <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= UART_RX_I;
         rx_q      <= sync_q;
         rx_prev_q <= RX_clock_enable ? rx_q : rx_prev_q;
      end
   end

   // Frame FSM: start detect, mid-bit sampling of 8 data bits LSB first, stop-bit sample
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done    = 1'b0;
      if (RX_clock_enable) begin
         case (state_q)
            S_IDLE: begin
               if (rx_prev_q && !rx_q) begin
                  cnt_d   = '0;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (cnt_q == HALF) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  state_d = rx_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  shift_d = {rx_q, shift_q[7:1]};
                  if (bit_q == 3'd7) state_d = S_STOP;
                  else bit_d = bit_q + 1'b1;
               end
            end
            S_STOP: begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end else if (state_q != S_IDLE && state_q != S_START && state_q != S_DATA && state_q != S_STOP) begin
         state_d = S_IDLE;
      end
   end

   // FSM state and counters
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Held byte and flags; a completing byte takes priority over a coincident unload
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         data_q  <= 8'h00;
         empty_q <= 1'b1;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (done) begin
         data_q  <= shift_q;
         empty_q <= 1'b0;
         ferr_q  <= ~rx_q;
         ovr_q   <= ~empty_q & ~Unload_data;
      end else if (Unload_data) begin
         empty_q <= 1'b1;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

   assign RX_data     = data_q;
   assign Empty       = empty_q;
   assign Frame_error = ferr_q;
   assign Overrun     = ovr_q;
endmodule
